uart_rx_param: RTL

//  Parametrised UART receiver, successor to the fixed 8-bit receiver FSM.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 20 ++
 rtl/uart_rx_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and bit-vote helper
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } rx_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an idle-high asynchronous line
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the raw line through two stages
    always_comb sync_d = {sync_q[0], d};

    // stages reset to the idle level so no false start is seen after reset
    always_ff @(posedge clk) sync_q <= reset ? 2'b11 : sync_d;

    assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote, parity/framing/overrun flags
import uart_pkg::*;

module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 uart_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);

    logic                 line_s;
    logic                 vote;
    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           hist_q, hist_d;
    logic                 perr_int_q, perr_int_d;
    logic                 ferr_int_q, ferr_int_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_in),
        .q     (line_s)
    );

    assign vote = maj3(hist_q);

    // frame FSM: all sampling advances on sample_tick, DONE always leaves after one clk
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        hist_d     = hist_q;
        perr_int_d = perr_int_q;
        ferr_int_d = ferr_int_q;
        if (sample_tick) begin
            hist_d     = {hist_q[1:0], line_s};
            tick_cnt_d = tick_cnt_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    if (hist_q[0] && !line_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == HALF_M1) begin
                        state_d    = vote ? S_IDLE : S_DATA;
                        tick_cnt_d = '0;
                        cnt_d      = '0;
                        perr_int_d = 1'b0;
                        ferr_int_d = 1'b0;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        shreg_d    = {vote, shreg_q[DATA_BITS-1:1]};
                        cnt_d      = cnt_q + 4'd1;
                        if (cnt_q == DB_M1) begin
                            cnt_d   = '0;
                            state_d = (PARITY == PAR_NONE) ? S_STOP : S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        perr_int_d = (^shreg_q) ^ vote ^ (PARITY == PAR_ODD);
                        state_d    = S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == FULL_M1) begin
                        tick_cnt_d = '0;
                        ferr_int_d = ferr_int_q | ~vote;
                        cnt_d      = cnt_q + 4'd1;
                        if (cnt_q == SB_M1) state_d = S_DONE;
                    end
                end
                default: ;
            endcase
        end
        if (state_q == S_DONE) state_d = S_IDLE;
    end

    // consumer handshake: deliver on DONE if the slot is free or being emptied, else flag overrun
    always_comb begin
        rx_data_d    = rx_data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        rx_valid_d   = rx_valid_q && !rx_ready;
        overrun_d    = 1'b0;
        if (state_q == S_DONE) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d    = shreg_q;
                parity_err_d = perr_int_q;
                frame_err_d  = ferr_int_q;
                rx_valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // state registers; reset discards any partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            hist_q       <= 3'b111;
            perr_int_q   <= 1'b0;
            ferr_int_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            hist_q       <= hist_d;
            perr_int_q   <= perr_int_d;
            ferr_int_q   <= ferr_int_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != S_IDLE);

endmodule
